// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bus of the PS/2 receiver: FIFO head, rdy/ack handshake and
// one-cycle status pulses.
interface ps2_rx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] code;
  logic                 rdy;
  logic                 ack;
  logic                 parity_error;
  logic                 frame_error;
  logic                 overflow;

  modport master (
    output code, rdy, parity_error, frame_error, overflow,
    input  ack
  );

  modport slave (
    input  code, rdy, parity_error, frame_error, overflow,
    output ack
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver in the system clock domain: synchronize and filter
// clk_k, decode start/data/parity/stop frames, buffer good codes in a FIFO.
module ps2_rx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_ODD  = 1,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_k,
  input  logic              data,
  ps2_rx_fifo_if.master     bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic ODD_L = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_PARITY = 2'd2, S_STOP = 2'd3} state_t;

  function automatic logic calc_par(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  logic                 k_meta_r, k_sync_r, d_meta_r, d_sync_r;
  logic                 k_f_r;
  logic [FW-1:0]        flt_cnt_r;
  logic                 flt_hit_s, fall_s, bit_s;
  state_t               state_r, state_nxt_s;
  logic                 stop_ev_s, to_hit_s, parity_ok_s;
  logic [BW-1:0]        bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_r;
  logic [19:0]          to_cnt_r;
  logic                 push_s, pop_s, wr_en_s, full_s, empty_s;
  logic                 fe_nxt_s, pe_nxt_s, ov_nxt_s;
  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r, rd_nxt_s;
  logic [CW-1:0]        count_r, count_nxt_s;
  logic [DATA_BITS-1:0] code_r, code_nxt_s;
  logic                 rdy_r, pe_r, fe_r, ov_r;

  // Two-flop synchronizers, preset to the idle bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      {k_meta_r, k_sync_r, d_meta_r, d_sync_r} <= 4'hF;
    end else begin
      {k_meta_r, k_sync_r} <= {clk_k, k_meta_r};
      {d_meta_r, d_sync_r} <= {data, d_meta_r};
    end
  end

  // The filtered clock follows only after FILTER_LEN consecutive differing samples.
  assign flt_hit_s = (k_sync_r != k_f_r) && (flt_cnt_r == FW'(FILTER_LEN - 1));
  assign fall_s    = flt_hit_s & k_f_r & ~k_sync_r;
  assign bit_s     = d_sync_r;

  // Glitch filter on the synchronized keyboard clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_f_r     <= 1'b1;
      flt_cnt_r <= '0;
    end else if (k_sync_r == k_f_r) begin
      flt_cnt_r <= '0;
    end else if (flt_hit_s) begin
      k_f_r     <= k_sync_r;
      flt_cnt_r <= '0;
    end else begin
      flt_cnt_r <= flt_cnt_r + FW'(1);
    end
  end

  assign to_hit_s    = (state_r != S_IDLE) && !fall_s && (to_cnt_r == TO_LAST);
  assign parity_ok_s = (calc_par(shift_r) ^ par_r) == ODD_L;

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Frame FSM next-state; advances only on fall events or a timeout.
  always_comb begin
    state_nxt_s = state_r;
    stop_ev_s   = 1'b0;
    if (to_hit_s) begin
      state_nxt_s = S_IDLE;
    end else if (fall_s) begin
      case (state_r)
        S_IDLE:   if (!bit_s) state_nxt_s = S_DATA; else state_nxt_s = S_IDLE;
        S_DATA:   if (bit_cnt_r == BW'(DATA_BITS - 1)) state_nxt_s = S_PARITY;
                  else state_nxt_s = S_DATA;
        S_PARITY: state_nxt_s = S_STOP;
        S_STOP:   begin state_nxt_s = S_IDLE; stop_ev_s = 1'b1; end
        default:  state_nxt_s = S_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Bit counter, shift register, parity capture and inter-edge timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r <= '0;
      shift_r   <= '0;
      par_r     <= 1'b0;
      to_cnt_r  <= '0;
    end else begin
      if (state_r == S_IDLE || to_hit_s || fall_s) to_cnt_r <= '0;
      else                                         to_cnt_r <= to_cnt_r + 20'd1;
      if (fall_s) begin
        case (state_r)
          S_IDLE:   bit_cnt_r <= '0;
          S_DATA:   begin
            shift_r   <= {bit_s, shift_r[DATA_BITS-1:1]};
            bit_cnt_r <= bit_cnt_r + BW'(1);
          end
          S_PARITY: par_r <= bit_s;
          default:  bit_cnt_r <= bit_cnt_r;
        endcase
      end
    end
  end

  // FIFO control; a pop frees the slot for a simultaneous push when full.
  always_comb begin
    empty_s     = (count_r == '0);
    full_s      = (count_r == CW'(FIFO_DEPTH));
    push_s      = stop_ev_s & bit_s & parity_ok_s;
    pop_s       = bus.ack & ~empty_s;
    wr_en_s     = push_s & (~full_s | pop_s);
    ov_nxt_s    = push_s & full_s & ~pop_s;
    fe_nxt_s    = (stop_ev_s & ~bit_s) | to_hit_s;
    pe_nxt_s    = stop_ev_s & bit_s & ~parity_ok_s;
    count_nxt_s = count_r + CW'(wr_en_s) - CW'(pop_s);
    rd_nxt_s    = rd_ptr_r + AW'(pop_s);
    if (count_nxt_s == '0)                   code_nxt_s = code_r;
    else if (wr_en_s && wr_ptr_r == rd_nxt_s) code_nxt_s = shift_r;
    else                                     code_nxt_s = mem_r[rd_nxt_s];
  end

  // FIFO storage, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      code_r   <= '0;
      rdy_r    <= 1'b0;
      pe_r     <= 1'b0;
      fe_r     <= 1'b0;
      ov_r     <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_nxt_s;
      count_r  <= count_nxt_s;
      code_r   <= code_nxt_s;
      rdy_r    <= (count_nxt_s != '0);
      pe_r     <= pe_nxt_s;
      fe_r     <= fe_nxt_s;
      ov_r     <= ov_nxt_s;
    end
  end

  assign bus.code         = code_r;
  assign bus.rdy          = rdy_r;
  assign bus.parity_error = pe_r;
  assign bus.frame_error  = fe_r;
  assign bus.overflow     = ov_r;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed + randomized bench for ps2_rx_fifo against a queue-based model.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;
  localparam int FL    = 4;
  localparam int TO    = 2000;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_k = 1'b1;
  logic data = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   pe_n = 0, fe_n = 0, ov_n = 0, fe_cyc = 0;
  int   exp_pe = 0, exp_fe = 0, exp_ov = 0;
  int   last_fall_cyc = 0;
  logic [7:0] q[$];

  ps2_rx_fifo_if #(.DATA_BITS(8)) bus_if ();

  ps2_rx_fifo #(
    .DATA_BITS(8), .PARITY_ODD(1), .FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .clk_k(clk_k), .data(data), .bus(bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Count status pulses (sampled away from the active edge).
  always @(negedge clk) begin
    if (bus_if.parity_error) pe_n <= pe_n + 1;
    if (bus_if.frame_error) begin fe_n <= fe_n + 1; fe_cyc <= cyc; end
    if (bus_if.overflow) ov_n <= ov_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One PS/2 frame (or its first nbits bits) at 100-cycle bit period.
  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_val,
                            input int nbits, input int glitch_bit);
    logic [10:0] fr;
    fr = {stop_val, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      data = fr[i];
      repeat (25) @(negedge clk);
      clk_k = 1'b0;
      last_fall_cyc = cyc;
      repeat (50) @(negedge clk);
      clk_k = 1'b1;
      if (i == glitch_bit) begin
        repeat (10) @(negedge clk);
        clk_k = 1'b0;
        repeat (FL - 1) @(negedge clk);
        clk_k = 1'b1;
        repeat (12) @(negedge clk);
      end else begin
        repeat (25) @(negedge clk);
      end
    end
    data = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_rdy"}, 32'(bus_if.rdy), 32'(q.size() != 0));
    if (q.size() != 0) chk({tag, "_code"}, 32'(bus_if.code), 32'(q[0]));
    chk({tag, "_pe"}, 32'(pe_n), 32'(exp_pe));
    chk({tag, "_fe"}, 32'(fe_n), 32'(exp_fe));
    chk({tag, "_ov"}, 32'(ov_n), 32'(exp_ov));
  endtask

  // Full frame plus model update: stop error wins over parity, then capacity.
  task automatic frame_and_check(input string tag, input logic [7:0] b, input logic par_flip,
                                 input logic stop_val, input int glitch_bit);
    send_frame(b, par_flip, stop_val, 11, glitch_bit);
    if (!stop_val)              exp_fe++;
    else if (par_flip)          exp_pe++;
    else if (q.size() == DEPTH) exp_ov++;
    else                        q.push_back(b);
    repeat (3) @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    bus_if.ack = 1'b1;
    @(negedge clk);
    bus_if.ack = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] rb;
    int kind, lo, hi, d;
    bus_if.ack = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_rdy", 32'(bus_if.rdy), 32'd0);
    chk("reset_code", 32'(bus_if.code), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_outputs("idle");

    frame_and_check("f1c", 8'h1C, 1'b0, 1'b1, -1);
    do_ack("ack1c");

    frame_and_check("badpar", 8'h1C, 1'b1, 1'b1, -1);
    frame_and_check("ff0", 8'hF0, 1'b0, 1'b1, -1);
    do_ack("ackf0");

    frame_and_check("badstop", 8'h5A, 1'b0, 1'b0, -1);

    // Short low glitch while idle, then another inside the frame.
    clk_k = 1'b0;
    repeat (FL - 1) @(negedge clk);
    clk_k = 1'b1;
    repeat (20) @(negedge clk);
    frame_and_check("glitch", 8'hA7, 1'b0, 1'b1, 4);
    do_ack("ackgl");

    // Stalled frame: start + 3 data bits, then clk_k stays high.
    send_frame(8'h29, 1'b0, 1'b1, 4, -1);
    for (int k = 0; k < TO + 100 && fe_n == exp_fe; k++) @(negedge clk);
    exp_fe++;
    d  = fe_cyc - last_fall_cyc;
    lo = TO + FL + 1;
    hi = TO + FL + 3;
    chk("timeout_seen", 32'(fe_n), 32'(exp_fe));
    chk("timeout_delay", 32'(d >= lo && d <= hi), 32'd1);
    frame_and_check("f29", 8'h29, 1'b0, 1'b1, -1);
    do_ack("ack29");

    for (int i = 1; i <= 5; i++) frame_and_check("fill", 8'(i), 1'b0, 1'b1, -1);
    chk("ov_once", 32'(ov_n), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 32'(bus_if.code), 32'(i + 1));
      do_ack("drain");
    end
    chk("drain_empty", 32'(bus_if.rdy), 32'd0);

    // Reset with a queued code and a partial frame in progress.
    frame_and_check("f3c", 8'h3C, 1'b0, 1'b1, -1);
    send_frame(8'h77, 1'b0, 1'b1, 3, -1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(bus_if.rdy), 32'd0);
    chk("rst_code", 32'(bus_if.code), 32'd0);
    chk("rst_pe", 32'(bus_if.parity_error), 32'd0);
    chk("rst_fe", 32'(bus_if.frame_error), 32'd0);
    chk("rst_ov", 32'(bus_if.overflow), 32'd0);
    q.delete();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_outputs("post_rst");

    for (int i = 0; i < 8; i++) begin
      rb   = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 9);
      frame_and_check("rand", rb, kind == 7, kind != 8, -1);
      if ($urandom_range(0, 1) == 1 && q.size() != 0) do_ack("rand_ack");
    end
    while (q.size() != 0) do_ack("final_drain");
    chk("final_rdy", 32'(bus_if.rdy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 keyboard receiver that runs entirely in the system clock domain. It oversamples the keyboard clock and data lines, filters glitches, and decodes start/data/parity/stop frames with a state machine. It checks parity and framing, recovers from stalled frames by timeout, and buffers received scan codes in a FIFO with a rdy/ack handshake toward the scan-code decoder and display logic.

## Interface
- DATA_BITS, 8: data bits per frame, LSB first.
- PARITY_ODD, 1: 1 selects odd parity (PS/2); 0 selects even parity.
- FILTER_LEN, 4: consecutive equal synchronized samples required before the filtered clk_k changes level (≥1).
- TIMEOUT_CYC, 50000: maximum clk cycles between falling edges within a frame (2 ≤ value < 2^20).
- FIFO_DEPTH, 4: scan-code buffer entries (power of 2, ≥2).
- clk  in  1  system clock; only clock in the block.
- rst  in  1  synchronous, active-high reset.
- clk_k  in  1  raw keyboard clock, asynchronous to clk.
- data  in  1  raw keyboard data, asynchronous to clk.
- code  out  DATA_BITS  FIFO head; valid only while rdy=1.
- rdy  out  1  FIFO not empty.
- ack  in  1  consumer pops the head; ignored while rdy=0.
- parity_error  out  1  one-cycle pulse: frame discarded for bad parity.
- frame_error  out  1  one-cycle pulse: stop bit was 0, or the frame timed out.
- overflow  out  1  one-cycle pulse: a good frame was dropped because the FIFO was full.

## Operation
- Input conditioning:
  - clk_k and data each pass through a 2-FF synchronizer.
  - Filtered clock k_f takes the synchronized clk_k value after FILTER_LEN consecutive equal samples.
  - A fall event is the cycle in which k_f is registered going 1→0. The bit value is the synchronized data in that same cycle.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions happen only on fall events, except for timeout.
  - IDLE: a fall event with bit=0 (start bit) → DATA, bit counter cleared. A fall event with bit=1 is ignored.
  - DATA: shift bits in LSB first. After DATA_BITS bits → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: the frame is good when stop=1 and the parity check passes. Always → IDLE.
- Parity check: (XOR of data bits ^ parity bit) must equal PARITY_ODD.
- STOP outcome precedence:
  - stop=0: frame_error only, frame discarded.
  - Else bad parity: parity_error only, frame discarded.
  - Else push to FIFO.
- Timeout: in any state other than IDLE, a counter increments each cycle and clears on each fall event.
  - When it reaches TIMEOUT_CYC: frame_error pulse, partial frame discarded, → IDLE.
  - The counter is held at 0 in IDLE.
- FIFO:
  - Push when full: the byte is dropped, overflow pulses, and contents are unchanged.
  - Push and pop in the same cycle while full: both take effect, no overflow.
  - Push and pop in the same cycle while empty: the byte is written and rdy rises next cycle; the pop is ignored.
  - code is held stable while rdy=1 and ack=0.
- Reset:
  - FSM to IDLE; counters cleared.
  - FIFO emptied.
  - Synchronizers and k_f set to 1 (bus idle level).
  - rdy, code, parity_error, frame_error and overflow all 0.
  - Reset mid-frame discards the partial frame. Receiving resumes with the next start bit after rst is deasserted.

## Timing
- A raw clk_k fall becomes a fall event 2 (synchronizer) + FILTER_LEN cycles later, ±1 cycle depending on sampling phase.
- Stop-bit fall event in cycle E:
  - FIFO written at the end of E.
  - rdy=1 and code valid in E+1 if the FIFO was empty.
  - Error and overflow pulses are high during E+1 only.
- Handshake timing:
  - ack with rdy=1 in cycle C: head advances at the end of C.
  - New code (or rdy=0 if the FIFO is now empty) appears in C+1.
  - Back-to-back acks pop one entry per cycle.
- A timeout reached at the end of cycle T produces frame_error in T+1. IDLE accepts a start bit from T+1.
- Minimum clk_k low/high time for reliable reception is (FILTER_LEN+2) clk cycles.

## Test plan
- Valid frame 0x1C (start 0, bits LSB first, parity 0, stop 1) at 10 kHz clk_k, default parameters -> rdy rises and code=0x1C; all error pulses 0. ack -> rdy=0 the next cycle.
- Frame 0x1C with parity bit 1 -> parity_error pulses once, rdy stays 0. A following good frame 0xF0 -> code=0xF0.
- Frame 0x5A with stop bit 0 -> frame_error pulses once, no push, no parity_error.
- clk_k low glitch of FILTER_LEN-1 cycles in IDLE, and again mid-frame -> no bit sampled. The frame still decodes correctly.
- Start bit plus 3 data bits, then clk_k held high -> frame_error exactly TIMEOUT_CYC cycles after the last fall event. The next frame 0x29 is received as code=0x29.
- Five good frames 0x01..0x05 with no ack (FIFO_DEPTH=4) -> overflow pulses on the 5th frame. Draining with ack yields 0x01..0x04 in order, then rdy=0. Apply rst mid-frame -> all outputs 0 and the FIFO is empty.
